// File: rtl/dpram_pkg.sv
// Shared types and constants for the port-2 arbiter of the 256x16 dual-port RAM.
package dpram_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 16;
  localparam int GID_W  = 3;

  // 2'd3 is not named; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/dpram_port2_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req after ptr, wrapping modulo N_REQ.
module rr_pick
  import dpram_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             valid,
  output logic [GID_W-1:0] winner
);

  // Walk the search order from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + k) % N_REQ))) begin
          valid  = 1'b1;
          winner = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dpram_port2_arbiter.sv
// Serialises N_REQ req/ack requesters onto RAM port 2 with round-robin priority.
module dpram_port2_arbiter
  import dpram_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = RAM_AW,
  parameter int DW    = RAM_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]   ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [GID_W-1:0]   grant_id,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  output logic               ram_rd,
  output logic               ram_wr,
  input  logic [DW-1:0]      ram_dout
);

  state_t           state, state_nxt;
  logic [GID_W-1:0] ptr, ptr_nxt;

  logic [N_REQ-1:0] ack_nxt;
  logic [DW-1:0]    rdata_nxt;
  logic             busy_nxt;
  logic [GID_W-1:0] grant_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [DW-1:0]    din_nxt;
  logic             rd_nxt;
  logic             wr_nxt;

  logic             pick_valid;
  logic [GID_W-1:0] pick_id;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_we;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == GID_W'(i)) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_we    = we[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ack_nxt   = ack;
    rdata_nxt = rdata;
    busy_nxt  = busy;
    grant_nxt = grant_id;
    addr_nxt  = ram_addr;
    din_nxt   = ram_din;
    rd_nxt    = ram_rd;
    wr_nxt    = ram_wr;
    case (state)
      ST_IDLE: begin
        ack_nxt  = '0;
        rd_nxt   = 1'b0;
        wr_nxt   = 1'b0;
        busy_nxt = 1'b0;
        if (pick_valid) begin
          state_nxt = ST_ACCESS;
          ptr_nxt   = pick_id;
          grant_nxt = pick_id;
          addr_nxt  = sel_addr;
          din_nxt   = sel_wdata;
          rd_nxt    = ~sel_we;
          wr_nxt    = sel_we;
          busy_nxt  = 1'b1;
        end
      end
      ST_ACCESS: begin
        // The RAM already acted on the falling edge; ram_rd still tells us whether it was a read.
        rd_nxt = 1'b0;
        wr_nxt = 1'b0;
        if (ram_rd) rdata_nxt = ram_dout;
        for (int i = 0; i < N_REQ; i++) begin
          ack_nxt[i] = (grant_id == GID_W'(i));
        end
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ack_nxt   = '0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        ack_nxt   = '0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= GID_W'(N_REQ - 1);
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_rd   <= 1'b0;
      ram_wr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      ack      <= ack_nxt;
      rdata    <= rdata_nxt;
      busy     <= busy_nxt;
      grant_id <= grant_nxt;
      ram_addr <= addr_nxt;
      ram_din  <= din_nxt;
      ram_rd   <= rd_nxt;
      ram_wr   <= wr_nxt;
    end
  end

endmodule

// File: doc/dpram_port2_arbiter.md
Name: dpram_port2_arbiter

Overview:
- Round-robin arbiter that shares port 2 of the 256x16 dual-port RAM between up to N_REQ peripheral requesters. Port 1 stays owned by the J1 core.
- Each requester uses a req/ack handshake. The arbiter serialises the requests into single rd/wr strobes on RAM port 2.
- For reads, it captures the RAM output and returns it to the requester with the ack.
- The arbiter runs on the rising edge. The RAM samples port 2 on the falling edge of the same cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 8, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester access request; held until the matching ack.
- we  in  N_REQ  per-requester command, 1 = write, 0 = read; stable while req is high.
- addr  in  N_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  N_REQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- ack  out  N_REQ  one-cycle completion pulse; one-hot or zero.
- rdata  out  DW  read data; valid only while ack is high for a read.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  3  index of the requester currently being served.
- ram_addr  out  AW  to RAM addr_2.
- ram_din  out  DW  to RAM d_in_2.
- ram_rd  out  1  to RAM rd_2.
- ram_wr  out  1  to RAM wr_2.
- ram_dout  in  DW  from RAM d_out_2.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, rdata=0, busy=0, grant_id=0, ram_addr=0, ram_din=0, ram_rd=0, ram_wr=0, FSM=IDLE, rr pointer=N_REQ-1 (so requester 0 has first priority).
- FSM states and transitions:
  - IDLE: if any req bit is set, select the winner by round-robin and move to ACCESS. In the same edge, latch the winner's addr into ram_addr and its wdata into ram_din, set ram_rd=~we or ram_wr=we, and set grant_id, the pointer (= winner) and busy=1. If no req bit is set, stay in IDLE.
  - ACCESS: exactly one cycle, with ram_rd or ram_wr high. The RAM performs the access on the falling edge. At the next posedge:
    - clear both strobes;
    - set rdata=ram_dout if the access was a read, otherwise leave rdata unchanged;
    - set ack[grant_id]=1;
    - move to ACK.
  - ACK: ack is high for this cycle only. The requester drops req at the closing edge. Next posedge: ack=0, busy=0, move to IDLE.
- Latency: 3 cycles from req sampled in IDLE to the end of ack. Maximum throughput is one access per 3 cycles.
- Round-robin rule: search indices pointer+1 .. pointer+N_REQ modulo N_REQ; the first set req wins. The pointer only updates on a grant.
- Starvation bound: a continuously held request is served within N_REQ grants.
- ram_rd and ram_wr are never high together and are never high outside ACCESS.
- Requests arriving during ACCESS or ACK wait; they are evaluated in the next IDLE.
- A requester that drops req before its ack is a protocol violation. The access still completes and is still acked.
- Width rules:
  - Addresses pass through unmodified; no wrap or offset logic.
  - When N_REQ < 8, grant_id upper bits are 0.
- rst during ACCESS or ACK:
  - returns the FSM to IDLE with all outputs at their reset values and no ack issued;
  - a write whose falling edge has already passed stays committed in the RAM; the requester must reissue after reset.
- With no req asserted, RAM port 2 stays idle (no strobes) indefinitely.

Decomposition:
- Shared package dpram_pkg:
  - FSM state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2 (2'd3 is illegal and recovers to IDLE);
  - RAM_AW=8 and RAM_DW=16 constants used as parameter defaults.
- One natural sub-module, rr_pick: combinational round-robin selector. Inputs are req and pointer; outputs are a valid flag and the winner index.
- The FSM, pointer register and datapath muxes stay in dpram_port2_arbiter.

Test Plan:
- Single write then read: requester 1 writes 0xBEEF to address 0x10, then reads 0x10. Expected: ram_wr high for exactly one cycle with ram_addr=0x10; ack[1] pulses; the read returns rdata=0xBEEF with ack[1]; every ack is 3 cycles after req.
- Round-robin fairness: all 4 requesters hold reads to addresses 0x00..0x03 after reset. Expected grant order 0,1,2,3,0,…; no requester is served twice before the others.
- Pointer wrap: pointer=3, req=4'b1001. Expected grant 0, then 3; the pointer ends at 3.
- Back-to-back same requester: requester 2 alone issues 5 consecutive writes. Expected 5 acks spaced exactly 3 cycles apart; strobes are never high in IDLE or ACK.
- Reset mid-access: assert rst in the cycle after the ACCESS edge of a read. Expected: no ack issued; all outputs return to 0; pointer=3; the next req from requester 0 is served normally.
- Strobe exclusivity: randomised req/we mix over 1000 cycles. Checker: ram_rd&ram_wr is never 1; ack is always one-hot or zero.
